// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-port, word-wide synchronous SRAM between the
//             instruction-fetch port and the load/store port. Arbitrates the
//             two requesters, maps byte addresses to word addresses, extracts
//             and extends load lanes, and turns sub-word stores into a
//             read-modify-write because the SRAM has no byte enables.
//  Options  : MEM_ARB_FIXED_PRIO_EN - when defined, the data port always wins
//             simultaneous requests; otherwise round-robin.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              resetn,
  // instruction-fetch port
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_valid,
  output logic              i_err,
  output logic [31:0]       i_rdata,
  // load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [2:0]        d_size,
  input  logic              d_signed,
  output logic              d_ready,
  output logic              d_err,
  output logic [XLEN-1:0]   d_rdata,
  // SRAM port
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [XLEN-1:0]   s_wdata,
  input  logic [XLEN-1:0]   s_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_I_RESP = 3'd1,
    S_D_RESP = 3'd2,
    S_RMW_WR = 3'd3,
    S_ERR_I  = 3'd4,
    S_ERR_D  = 3'd5
  } state_t;

  state_t r_state;
  logic   r_i_valid;
  logic   r_i_err;
  logic   r_d_ready;
  logic   r_d_err;

`ifndef MEM_ARB_FIXED_PRIO_EN
  localparam logic c_GRANT_FETCH = 1'b0;
  localparam logic c_GRANT_DATA  = 1'b1;
  logic   r_last_grant;
`endif

  logic [2:0]      w_off;
  logic [5:0]      w_shamt;
  logic            w_i_bad;
  logic            w_d_misalign;
  logic            w_d_bad;
  logic            w_d_double;
  logic            w_d_pick;
  logic            w_idle;
  logic            w_gnt_i;
  logic            w_gnt_d;
  logic [XLEN-1:0] w_size_mask;
  logic [XLEN-1:0] w_merged;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_load;

  assign w_off      = d_addr[2:0];
  assign w_shamt    = {w_off, 3'b000};
  assign w_d_double = (d_size == 3'd3);

  // Fetch must be word aligned and fall inside the SRAM.
  assign w_i_bad = (i_addr[1:0] != 2'b00) || (i_addr[31:ADDR_W+3] != '0);

  // Offset must be a multiple of the access size; sizes above a double are illegal.
  always_comb begin
    w_d_misalign = 1'b1;
    case (d_size)
      3'd0:    w_d_misalign = 1'b0;
      3'd1:    w_d_misalign = w_off[0];
      3'd2:    w_d_misalign = (w_off[1:0] != 2'b00);
      3'd3:    w_d_misalign = (w_off != 3'b000);
      default: w_d_misalign = 1'b1;
    endcase
  end

  assign w_d_bad = w_d_misalign || (d_addr[XLEN-1:ADDR_W+3] != '0);

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign w_d_pick = d_req;
`else
  assign w_d_pick = d_req && (!i_req || (r_last_grant == c_GRANT_FETCH));
`endif

  // Grants exist only in IDLE and never while reset is asserted, so reset
  // immediately silences the SRAM side.
  assign w_idle  = resetn && (r_state == S_IDLE);
  assign w_gnt_d = w_idle && w_d_pick;
  assign w_gnt_i = w_idle && i_req && !w_d_pick;

  // Lane mask for the access size, right-aligned.
  always_comb begin
    w_size_mask = '1;
    case (d_size[1:0])
      2'd0:    w_size_mask = {{(XLEN-8){1'b0}},  8'hFF};
      2'd1:    w_size_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
      2'd2:    w_size_mask = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
      default: w_size_mask = '1;
    endcase
  end

  // Replace the addressed lanes of the read word with the low bytes of the store data.
  assign w_merged = (s_rdata & ~(w_size_mask << w_shamt)) |
                    ((d_wdata & w_size_mask) << w_shamt);

  // Right-align the addressed lanes and extend to full width.
  assign w_shifted = s_rdata >> w_shamt;
  always_comb begin
    w_load = w_shifted;
    case (d_size[1:0])
      2'd0:    w_load = {{(XLEN-8){d_signed & w_shifted[7]}},   w_shifted[7:0]};
      2'd1:    w_load = {{(XLEN-16){d_signed & w_shifted[15]}}, w_shifted[15:0]};
      2'd2:    w_load = {{(XLEN-32){d_signed & w_shifted[31]}}, w_shifted[31:0]};
      default: w_load = w_shifted;
    endcase
  end

  // SRAM controls decoded from state and the current grant.
  always_comb begin
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    if (w_gnt_i && !w_i_bad) begin
      s_addr = i_addr[ADDR_W+2:3];
    end else if (w_gnt_d && !w_d_bad) begin
      s_addr = d_addr[ADDR_W+2:3];
      if (d_we && w_d_double) begin
        s_we    = 1'b1;
        s_wdata = d_wdata;
      end
    end else if (r_state == S_RMW_WR) begin
      s_we    = 1'b1;
      s_addr  = d_addr[ADDR_W+2:3];
      s_wdata = w_merged;
    end
  end

  // Arbitration FSM with registered done pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_i_valid    <= 1'b0;
      r_i_err      <= 1'b0;
      r_d_ready    <= 1'b0;
      r_d_err      <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      r_last_grant <= c_GRANT_DATA;
`endif
    end else begin
      r_i_valid <= 1'b0;
      r_i_err   <= 1'b0;
      r_d_ready <= 1'b0;
      r_d_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_i) begin
`ifndef MEM_ARB_FIXED_PRIO_EN
            r_last_grant <= c_GRANT_FETCH;
`endif
            if (w_i_bad) begin
              r_state <= S_ERR_I;
              r_i_err <= 1'b1;
            end else begin
              r_state   <= S_I_RESP;
              r_i_valid <= 1'b1;
            end
          end else if (w_gnt_d) begin
`ifndef MEM_ARB_FIXED_PRIO_EN
            r_last_grant <= c_GRANT_DATA;
`endif
            if (w_d_bad) begin
              r_state <= S_ERR_D;
              r_d_err <= 1'b1;
            end else if (d_we && !w_d_double) begin
              r_state <= S_RMW_WR;
            end else begin
              r_state   <= S_D_RESP;
              r_d_ready <= 1'b1;
            end
          end
        end
        S_RMW_WR: begin
          r_state   <= S_D_RESP;
          r_d_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign i_valid = r_i_valid;
  assign i_err   = r_i_err;
  assign d_ready = r_d_ready;
  assign d_err   = r_d_err;

  assign i_rdata = !r_i_valid ? 32'd0 : (i_addr[2] ? s_rdata[63:32] : s_rdata[31:0]);
  assign d_rdata = (r_d_ready && !d_we) ? w_load : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed, table-driven bench for mem_port_arbiter with a
//             behavioural synchronous SRAM.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_valid, i_err;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [63:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic [2:0]  d_size = '0;
  logic        d_signed = 1'b0;
  logic        d_ready, d_err;
  logic [63:0] d_rdata;
  logic        s_we;
  logic [17:0] s_addr;
  logic [63:0] s_wdata;
  logic [63:0] s_rdata;

  mem_port_arbiter #(.XLEN(64), .ADDR_W(18)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_signed(d_signed), .d_ready(d_ready), .d_err(d_err), .d_rdata(d_rdata),
    .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM, read-first, with a backdoor write port for preloading.
  logic [63:0] mem [0:262143];
  logic        bd_we = 1'b0;
  logic [17:0] bd_addr = '0;
  logic [63:0] bd_data = '0;
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (s_we) mem[s_addr] <= s_wdata;
    s_rdata <= mem[s_addr];
  end

  // Count SRAM write cycles, sampled mid-cycle.
  int we_total = 0;
  always @(negedge clk) if (s_we === 1'b1) we_total++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [17:0] wa, input logic [63:0] val);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_addr = wa; bd_data = val;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  size;
    bit          sgn;
    logic [63:0] pre;
    logic [63:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
    int          exp_we;
    logic [63:0] exp_word;
  } vec_t;

  function automatic vec_t mk(bit is_d, bit we, logic [63:0] addr, logic [63:0] wdata,
                              logic [2:0] size, bit sgn, logic [63:0] pre,
                              logic [63:0] exp_rdata, bit exp_err, int exp_lat,
                              int exp_we, logic [63:0] exp_word);
    vec_t v;
    v.is_d = is_d; v.we = we; v.addr = addr; v.wdata = wdata; v.size = size;
    v.sgn = sgn; v.pre = pre; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    v.exp_lat = exp_lat; v.exp_we = exp_we; v.exp_word = exp_word;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int          cyc;
    int          base;
    bit          done;
    bit          ok;
    bit          er;
    logic [63:0] rd;
    preload(v.addr[20:3], v.pre);
    @(posedge clk); #1;
    base = we_total;
    if (v.is_d) begin
      d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_size = v.size; d_signed = v.sgn;
      d_req = 1'b1;
    end else begin
      i_addr = v.addr[31:0];
      i_req  = 1'b1;
    end
    cyc = 0; done = 1'b0; ok = 1'b0; er = 1'b0; rd = '0;
    while (!done && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
      if (v.is_d ? (d_ready | d_err) : (i_valid | i_err)) begin
        done = 1'b1;
        rd   = v.is_d ? d_rdata : {32'd0, i_rdata};
        er   = v.is_d ? d_err : i_err;
        ok   = v.is_d ? d_ready : i_valid;
      end
    end
    d_req = 1'b0;
    i_req = 1'b0;
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_lat"}, 64'(cyc), 64'(v.exp_lat));
    check({tag, "_okerr"}, {62'd0, ok, er}, {62'd0, !v.exp_err, v.exp_err});
    check({tag, "_rdata"}, rd, v.exp_rdata);
    @(posedge clk); #1;
    check({tag, "_pulse1"}, {60'd0, i_valid, i_err, d_ready, d_err}, 64'd0);
    check({tag, "_we_cnt"}, 64'(we_total - base), 64'(v.exp_we));
    if (v.we) check({tag, "_word"}, mem[v.addr[20:3]], v.exp_word);
  endtask

  task automatic arb_round(output int ci, output int cd);
    int c;
    ci = 0; cd = 0; c = 0;
    @(posedge clk); #1;
    i_addr = 32'h100; i_req = 1'b1;
    d_we = 1'b0; d_addr = 64'h200; d_size = 3'd3; d_signed = 1'b0; d_req = 1'b1;
    while ((i_req || d_req) && c < 10) begin
      @(posedge clk); #1;
      c++;
      if (i_valid | i_err) begin ci = c; i_req = 1'b0; end
      if (d_ready | d_err) begin cd = c; d_req = 1'b0; end
    end
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t vecs[18];
  int   ci, cd, base;

  initial begin
    vecs[0]  = mk(0, 0, 64'h100, 0, 0, 0, 64'hDEADBEEF_00000013, 64'h13,         0, 1, 0, 0);
    vecs[1]  = mk(0, 0, 64'h104, 0, 0, 0, 64'hDEADBEEF_00000013, 64'hDEADBEEF,   0, 1, 0, 0);
    vecs[2]  = mk(1, 0, 64'h205, 0, 0, 1, 64'h0000_8000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80, 0, 1, 0, 0);
    vecs[3]  = mk(1, 0, 64'h205, 0, 0, 0, 64'h0000_8000_0000_0000, 64'h80,       0, 1, 0, 0);
    vecs[4]  = mk(1, 0, 64'h200, 0, 3, 0, 64'h0000_8000_0000_0000, 64'h0000_8000_0000_0000, 0, 1, 0, 0);
    vecs[5]  = mk(1, 1, 64'h306, 64'h12345678_9ABCBEEF, 1, 0, 64'h1111_1111_1111_1111, 0, 0, 2, 1,
                  64'hBEEF_1111_1111_1111);
    vecs[6]  = mk(1, 0, 64'h202, 0, 2, 0, 64'h0000_8000_0000_0000, 0, 1, 1, 0, 0);
    vecs[7]  = mk(0, 0, 64'h102, 0, 0, 0, 64'hDEADBEEF_00000013, 0, 1, 1, 0, 0);
    vecs[8]  = mk(1, 1, 64'h400, 64'hA5A5_5A5A_0F0F_F0F0, 3, 0, 64'h0, 0, 0, 1, 1, 64'hA5A5_5A5A_0F0F_F0F0);
    vecs[9]  = mk(1, 1, 64'h409, 64'hFF7E, 0, 0, 64'h0, 0, 0, 2, 1, 64'h7E00);
    vecs[10] = mk(1, 1, 64'h414, 64'hFFFFFFFF_CAFEF00D, 2, 0, 64'h01234567_89ABCDEF, 0, 0, 2, 1,
                  64'hCAFEF00D_89ABCDEF);
    vecs[11] = mk(1, 0, 64'h502, 0, 1, 1, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001, 0, 1, 0, 0);
    vecs[12] = mk(1, 0, 64'h604, 0, 2, 0, 64'hF0000001_12345678, 64'h0000_0000_F000_0001, 0, 1, 0, 0);
    vecs[13] = mk(1, 0, 64'h604, 0, 2, 1, 64'hF0000001_12345678, 64'hFFFF_FFFF_F000_0001, 0, 1, 0, 0);
    vecs[14] = mk(1, 0, 64'h0020_0000, 0, 3, 0, 64'h0, 0, 1, 1, 0, 0);
    vecs[15] = mk(0, 0, 64'h0020_0000, 0, 0, 0, 64'h0, 0, 1, 1, 0, 0);
    vecs[16] = mk(1, 0, 64'h700, 0, 3'd4, 0, 64'h8000_0000_0000_0001, 0, 1, 1, 0, 0);
    vecs[17] = mk(1, 1, 64'h301, 64'hBEEF, 1, 0, 64'h2222_2222_2222_2222, 0, 1, 1, 0,
                  64'h2222_2222_2222_2222);

    // Reset with both ports requesting: every output must stay 0.
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h200; d_size = 3'd3; d_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sram", {45'd0, s_we, s_addr}, 64'd0);
    check("rst_swdata", s_wdata, 64'd0);
    check("rst_pulses", {60'd0, i_valid, i_err, d_ready, d_err}, 64'd0);
    check("rst_rdata", d_rdata | {32'd0, i_rdata}, 64'd0);
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    resetn = 1'b1;

    // Simultaneous requests straight out of reset, two rounds.
    preload(18'h20, 64'hDEADBEEF_00000013);
    arb_round(ci, cd);
`ifdef MEM_ARB_FIXED_PRIO_EN
    check("arb1_fetch_cyc", 64'(ci), 64'd3);
    check("arb1_data_cyc", 64'(cd), 64'd1);
`else
    check("arb1_fetch_cyc", 64'(ci), 64'd1);
    check("arb1_data_cyc", 64'(cd), 64'd3);
`endif
    arb_round(ci, cd);
`ifdef MEM_ARB_FIXED_PRIO_EN
    check("arb2_fetch_cyc", 64'(ci), 64'd3);
    check("arb2_data_cyc", 64'(cd), 64'd1);
`else
    check("arb2_fetch_cyc", 64'(ci), 64'd1);
    check("arb2_data_cyc", 64'(cd), 64'd3);
`endif

    // Directed vector table.
    for (int k = 0; k < 18; k++) run_vec(vecs[k], $sformatf("v%0d", k));

    // Reset asserted in the cycle after a sub-word store grant.
    preload(18'hA0, 64'h1122_3344_5566_7788);
    @(posedge clk); #1;
    base = we_total;
    d_we = 1'b1; d_addr = 64'h501; d_size = 3'd0; d_wdata = 64'hAB; d_signed = 1'b0; d_req = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    check("rmwrst_swe_now", {63'd0, s_we}, 64'd0);
    d_req = 1'b0;
    @(posedge clk); #1;
    check("rmwrst_pulses", {60'd0, i_valid, i_err, d_ready, d_err}, 64'd0);
    check("rmwrst_sram", {45'd0, s_we, s_addr}, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    check("rmwrst_we_cnt", 64'(we_total - base), 64'd0);
    check("rmwrst_word", mem[18'hA0], 64'h1122_3344_5566_7788);
    run_vec(vecs[0], "post_rst_fetch");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
